// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : state encodings, defaults and control-bundle helpers
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        PC_ST_RUN      = 2'd0,
        PC_ST_HAZ      = 2'd1,
        PC_ST_MEM_WAIT = 2'd2,
        PC_ST_ERR      = 2'd3
    } pc_state_e;

    localparam int PC_WAIT_MAX_DEF = 16;
    localparam int PC_CNT_W_DEF    = 16;
    localparam int PC_WAIT_CNT_W   = 8;

    typedef struct packed {
        logic pc_en;
        logic xreg1_en;
        logic xreg2_en;
        logic xreg3_en;
        logic xreg4_en;
        logic xreg1_flush;
        logic xreg2_flush;
    } pc_ctrl_t;

    // Every register loads; flushes chosen by the caller.
    function automatic pc_ctrl_t pc_all_en(input logic flush1, input logic flush2);
        pc_ctrl_t c;
        c.pc_en       = 1'b1;
        c.xreg1_en    = 1'b1;
        c.xreg2_en    = 1'b1;
        c.xreg3_en    = 1'b1;
        c.xreg4_en    = 1'b1;
        c.xreg1_flush = flush1;
        c.xreg2_flush = flush2;
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
// ============================================================================
// sat_counter : W-bit up-counter that sticks at all-ones
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : 5-stage pipeline sequencer (stall/flush/memory-wait timeout)
// Optional performance counters under PIPE_CTRL_PERF_EN.  Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = PC_WAIT_MAX_DEF,
    parameter int CNT_W    = PC_CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             do_hazard,
    input  logic             do_jump,
    input  logic             dm_req,
    input  logic             dm_ack,
    output logic             pc_en,
    output logic             xreg1_en,
    output logic             xreg2_en,
    output logic             xreg3_en,
    output logic             xreg4_en,
    output logic             xreg1_flush,
    output logic             xreg2_flush,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [PC_WAIT_CNT_W-1:0] WAIT_LIM = PC_WAIT_CNT_W'(WAIT_MAX);

    pc_state_e                state_q,    state_d;
    logic [PC_WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                     jump_pend_q, jump_pend_d;
    pc_ctrl_t                 ctrl_d;
    pc_ctrl_t                 ctrl;
    logic                     mem_stall;

    assign mem_stall = dm_req & ~dm_ack;

    always_comb begin
        ctrl_d      = '0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        jump_pend_d = jump_pend_q;

        case (state_q)
            PC_ST_RUN, PC_ST_HAZ: begin
                if (mem_stall) begin
                    state_d     = PC_ST_MEM_WAIT;
                    wait_cnt_d  = PC_WAIT_CNT_W'(1);
                    jump_pend_d = do_jump;
                end else if (do_jump) begin
                    // The hazarding instruction is itself being squashed.
                    ctrl_d  = pc_all_en(1'b1, 1'b1);
                    state_d = PC_ST_RUN;
                end else if (do_hazard && (state_q == PC_ST_RUN)) begin
                    ctrl_d.xreg2_en    = 1'b1;
                    ctrl_d.xreg2_flush = 1'b1;
                    ctrl_d.xreg3_en    = 1'b1;
                    ctrl_d.xreg4_en    = 1'b1;
                    state_d            = PC_ST_HAZ;
                end else begin
                    ctrl_d  = pc_all_en(1'b0, 1'b0);
                    state_d = PC_ST_RUN;
                end
            end

            PC_ST_MEM_WAIT: begin
                if (dm_ack) begin
                    ctrl_d      = pc_all_en(jump_pend_q, jump_pend_q);
                    jump_pend_d = 1'b0;
                    wait_cnt_d  = '0;
                    state_d     = PC_ST_RUN;
                end else if (wait_cnt_q >= WAIT_LIM) begin
                    jump_pend_d = 1'b0;
                    wait_cnt_d  = '0;
                    state_d     = PC_ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + PC_WAIT_CNT_W'(1);
                end
            end

            default: begin
                state_d = PC_ST_ERR;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= PC_ST_RUN;
            wait_cnt_q  <= '0;
            jump_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            jump_pend_q <= jump_pend_d;
        end
    end

    // State already reads RUN during reset, so the outputs need explicit gating.
    assign ctrl = reset ? ctrl_d : '0;

    assign pc_en       = ctrl.pc_en;
    assign xreg1_en    = ctrl.xreg1_en;
    assign xreg2_en    = ctrl.xreg2_en;
    assign xreg3_en    = ctrl.xreg3_en;
    assign xreg4_en    = ctrl.xreg4_en;
    assign xreg1_flush = ctrl.xreg1_flush;
    assign xreg2_flush = ctrl.xreg2_flush;
    assign bus_error   = (state_q == PC_ST_ERR);

`ifdef PIPE_CTRL_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (~ctrl.pc_en),
        .clr   (1'b0),
        .q     (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (ctrl.xreg1_flush),
        .clr   (1'b0),
        .q     (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed self-checking bench for pipe_ctrl (WAIT_MAX=4)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    localparam int CNT_W = 16;
`ifdef PIPE_CTRL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    // {pc_en, xreg1_en..xreg4_en, xreg1_flush, xreg2_flush}
    localparam logic [6:0] C_NONE = 7'b00000_00;
    localparam logic [6:0] C_ALL  = 7'b11111_00;
    localparam logic [6:0] C_JUMP = 7'b11111_11;
    localparam logic [6:0] C_HAZ  = 7'b00111_01;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             do_hazard = 1'b0;
    logic             do_jump = 1'b0;
    logic             dm_req = 1'b0;
    logic             dm_ack = 1'b0;
    logic             pc_en, xreg1_en, xreg2_en, xreg3_en, xreg4_en;
    logic             xreg1_flush, xreg2_flush, bus_error;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_chk = 0;
    int n_bad = 0;

    pipe_ctrl #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .do_hazard    (do_hazard),
        .do_jump      (do_jump),
        .dm_req       (dm_req),
        .dm_ack       (dm_ack),
        .pc_en        (pc_en),
        .xreg1_en     (xreg1_en),
        .xreg2_en     (xreg2_en),
        .xreg3_en     (xreg3_en),
        .xreg4_en     (xreg4_en),
        .xreg1_flush  (xreg1_flush),
        .xreg2_flush  (xreg2_flush),
        .bus_error    (bus_error),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] outs();
        return {25'd0, pc_en, xreg1_en, xreg2_en, xreg3_en, xreg4_en, xreg1_flush, xreg2_flush};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs, then wait to the falling edge where Mealy outputs are stable.
    task automatic apply(input logic h, input logic j, input logic r, input logic a);
        do_hazard = h;
        do_jump   = j;
        dm_req    = r;
        dm_ack    = a;
        @(negedge clock);
    endtask

    task automatic adv();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        do_hazard = 1'b0; do_jump = 1'b0; dm_req = 1'b0; dm_ack = 1'b0;
        adv();
        @(negedge clock);
        reset = 1'b1;
        adv();
    endtask

    initial begin
        // Reset held with hostile inputs
        reset = 1'b0;
        do_jump = 1'b1;
        dm_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_ctrl", outs(), {25'd0, C_NONE});
            check("rst_berr", {31'd0, bus_error}, 32'd0);
        end
        check("rst_stall", {16'd0, stall_cycles}, 32'd0);
        reset = 1'b1;
        apply(0, 0, 0, 0);
        check("post_rst", outs(), {25'd0, C_ALL});
        adv();

        // Load-use bubble
        do_reset();
        apply(1, 0, 0, 0);
        check("lu_c1", outs(), {25'd0, C_HAZ});
        adv();
        apply(1, 0, 0, 0);
        check("lu_c2", outs(), {25'd0, C_ALL});
        adv();
        check("lu_stall", {16'd0, stall_cycles}, 32'(PERF));

        // Jump beats hazard; a following hazard must still bubble (state RUN)
        do_reset();
        apply(1, 1, 0, 0);
        check("jh_ctrl", outs(), {25'd0, C_JUMP});
        adv();
        apply(1, 0, 0, 0);
        check("jh_run", outs(), {25'd0, C_HAZ});
        adv();
        check("jh_fcnt", {16'd0, flush_count}, 32'(PERF));

        // Memory wait with a jump latched in the request cycle
        do_reset();
        apply(0, 1, 1, 0);
        check("mw_c0", outs(), {25'd0, C_NONE});
        adv();
        apply(0, 0, 1, 0);
        check("mw_c1", outs(), {25'd0, C_NONE});
        adv();
        apply(0, 0, 1, 0);
        check("mw_c2", outs(), {25'd0, C_NONE});
        adv();
        apply(0, 0, 1, 1);
        check("mw_ack", outs(), {25'd0, C_JUMP});
        adv();
        apply(0, 0, 0, 0);
        check("mw_after", outs(), {25'd0, C_ALL});
        adv();
        check("mw_stall", {16'd0, stall_cycles}, 32'(3 * PERF));
        check("mw_fcnt", {16'd0, flush_count}, 32'(PERF));

        // Timeout: request cycle, four wait cycles, then ERR
        do_reset();
        apply(0, 0, 1, 0);
        check("to_req", outs(), {25'd0, C_NONE});
        adv();
        for (int k = 1; k <= 4; k++) begin
            apply(0, 0, 1, 0);
            check("to_wait_berr", {31'd0, bus_error}, 32'd0);
            adv();
        end
        apply(0, 0, 1, 0);
        check("to_berr", {31'd0, bus_error}, 32'd1);
        check("to_ctrl", outs(), {25'd0, C_NONE});
        adv();
        apply(0, 0, 1, 1);
        check("to_ack_ign", outs(), {25'd0, C_NONE});
        adv();
        apply(0, 0, 0, 0);
        check("to_sticky", {31'd0, bus_error}, 32'd1);
        adv();
        do_reset();
        apply(0, 0, 0, 0);
        check("to_rst_berr", {31'd0, bus_error}, 32'd0);
        check("to_rst_ctrl", outs(), {25'd0, C_ALL});
        adv();

        // Ack arriving exactly on the limit cycle wins
        do_reset();
        apply(0, 0, 1, 0);
        adv();
        for (int k = 1; k <= 3; k++) begin
            apply(0, 0, 1, 0);
            adv();
        end
        apply(0, 0, 1, 1);
        check("al_ack", outs(), {25'd0, C_ALL});
        adv();
        apply(0, 0, 0, 0);
        check("al_run", outs(), {25'd0, C_ALL});
        check("al_berr", {31'd0, bus_error}, 32'd0);
        adv();

        // Zero-wait access and a stray ack cause no stall
        apply(0, 0, 1, 1);
        check("zero_wait", outs(), {25'd0, C_ALL});
        adv();
        apply(0, 0, 0, 1);
        check("stray_ack", outs(), {25'd0, C_ALL});
        adv();

        // Reset mid-wait drops the latched jump
        apply(0, 1, 1, 0);
        adv();
        do_reset();
        apply(0, 0, 1, 0);
        adv();
        apply(0, 0, 1, 1);
        check("rst_jpend", outs(), {25'd0, C_ALL});
        adv();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline sequencer for the 5-stage core.
- Consumes the load-use `do_hazard` from the forwarding unit, the EX-stage jump/branch decision and the data-memory handshake.
- Generates per-stage register enables and flushes for PC, xREG1..xREG4.
- Contains a memory-wait state machine with timeout, so a stalled bus cannot hang the core silently.

Parameters:
- WAIT_MAX, 16: maximum consecutive MEM_WAIT cycles before declaring a bus error (1..255).
- CNT_W, 16: width of the performance counters.

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- do_hazard  in  1  load-use hazard from the forwarding unit (combinational, ID stage).
- do_jump  in  1  branch/jump taken, resolved in EX (xREG2 stage).
- dm_req  in  1  MEM-stage instruction accesses data memory this cycle.
- dm_ack  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- xreg1_en, xreg2_en, xreg3_en, xreg4_en  out  1 each  pipeline register load enables.
- xreg1_flush, xreg2_flush  out  1 each  load a bubble (control fields zeroed) into xREG1 / xREG2.
- bus_error  out  1  sticky memory-timeout flag.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0 (optional feature).
- flush_count  out  CNT_W  saturating count of jump flushes (optional feature).

Behaviour:
- States:
  - RUN: normal operation.
  - HAZ: one-cycle load-use bubble.
  - MEM_WAIT: whole pipeline frozen.
  - ERR: dead, terminal.
- Encodings are 2-bit, held in a registered state.
- Outputs are combinational from state and inputs (Mealy).
- While reset is low:
  - state goes to RUN, wait_cnt=0, bus_error=0, counters=0.
  - All enables and flushes are forced 0 regardless of inputs.
- RUN, priority high to low:
  - (a) dm_req & !dm_ack:
    - All enables 0, flushes 0.
    - Next state MEM_WAIT, wait_cnt=1.
    - A do_jump in the same cycle is latched into jump_pend.
  - (b) do_jump:
    - All enables 1, xreg1_flush=1, xreg2_flush=1.
    - The hazard is ignored, because its instruction is being flushed.
  - (c) do_hazard:
    - pc_en=0, xreg1_en=0, xreg2_en=1 with xreg2_flush=1, xreg3_en=xreg4_en=1.
    - Next state HAZ.
  - (d) otherwise: all enables 1, flushes 0.
- HAZ:
  - Lasts exactly one cycle.
  - do_hazard is ignored.
  - Behaves as RUN cases (a), (b), (d).
  - Next state RUN, unless case (a) moves it to MEM_WAIT.
- MEM_WAIT:
  - All enables 0; wait_cnt increments each cycle.
  - On dm_ack:
    - All enables 1 this cycle.
    - If jump_pend, xreg1_flush=xreg2_flush=1, then jump_pend clears.
    - Next state RUN; do_hazard is not evaluated in the ack cycle.
  - If wait_cnt==WAIT_MAX and !dm_ack: next state ERR.
  - dm_ack on the WAIT_MAX cycle wins over timeout.
- ERR:
  - bus_error=1, all enables 0, flushes 0.
  - Only reset leaves ERR.
- dm_ack in RUN/HAZ with dm_req=1 is a zero-wait access; no stall.
- dm_ack with dm_req=0 is ignored everywhere except MEM_WAIT.
- wait_cnt is an 8-bit counter, cleared on leaving MEM_WAIT.
- Reset mid-MEM_WAIT or mid-HAZ discards jump_pend and any pending bubble.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined:
  - stall_cycles increments each non-reset cycle with pc_en=0.
  - flush_count increments each cycle with xreg1_flush=1.
  - Both saturate at all-ones.
- When undefined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- State encodings (PC_ST_RUN/HAZ/MEM_WAIT/ERR) go in a shared header `def_pipe.v`, alongside the existing mux-select defines.
- WAIT_MAX default goes in the same header.
- One natural sub-module: sat_counter (parameter W; ports clock, reset, inc, clr, q), instantiated twice under PIPE_CTRL_PERF_EN.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 3 cycles with do_jump=1, dm_req=1.
  - Required: all enables/flushes 0, bus_error=0; first cycle after release, idle inputs give all enables 1.
- Load-use:
  - Stimulus: do_hazard=1 held for 2 cycles.
  - Required: cycle 1 pc_en=0, xreg1_en=0, xreg2_flush=1; cycle 2 (HAZ) all enables 1, flushes 0; stall_cycles=1.
- Jump vs hazard:
  - Stimulus: do_jump=1 and do_hazard=1 together.
  - Required: pc_en=1, xreg1_flush=xreg2_flush=1, state stays RUN; flush_count=1.
- Memory wait with latched jump:
  - Stimulus: dm_req=1, dm_ack=0, do_jump=1; dm_ack rises 3 cycles later.
  - Required: enables 0 for 3 cycles; ack cycle enables 1 with both flushes 1; stall_cycles=3.
- Timeout (WAIT_MAX=4):
  - Stimulus: dm_req=1, dm_ack never.
  - Required: bus_error=1 from the 5th cycle and stays set; a later dm_ack=1 has no effect until reset.
- Ack on limit:
  - Stimulus: WAIT_MAX=4, dm_ack on wait_cnt==4.
  - Required: return to RUN, bus_error=0.
